// File: rtl/inv_shift_rows_stream_if.sv
// inv_shift_rows_stream_if: byte stream with valid/ready/last; master drives valid/data/last, slave drives ready
interface inv_shift_rows_stream_if #(
  parameter int BYTE_W = 8
);
  logic              valid;
  logic              ready;
  logic              last;
  logic [BYTE_W-1:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/inv_shift_rows_stream.sv
// inv_shift_rows_stream: byte-serial AES (Inv)ShiftRows with 2-bank ping-pong buffering and valid/ready on both sides
module inv_shift_rows_stream #(
  parameter int BYTE_W  = 8,
  parameter bit INVERSE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync_clr,
  inv_shift_rows_stream_if.slave  in_if,
  inv_shift_rows_stream_if.master out_if
);
  logic [BYTE_W-1:0] bank_q [2][16];
  logic [BYTE_W-1:0] bank_d [2][16];
  logic [3:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              in_ready, out_valid, wr_fire, rd_fire, wr_done, rd_done;
  logic [1:0]        col, row, src_col;
  assign in_ready      = !full_q[wr_bank_q];
  assign out_valid     = full_q[rd_bank_q];
  assign in_if.ready   = in_ready;
  assign out_if.valid  = out_valid;
  assign wr_fire       = in_if.valid && in_ready;
  assign rd_fire       = out_valid && out_if.ready;
  assign wr_done       = wr_fire && wr_cnt_q == 4'd15;
  assign rd_done       = rd_fire && rd_cnt_q == 4'd15;
  assign col           = rd_cnt_q[3:2];
  assign row           = rd_cnt_q[1:0];
  assign src_col       = INVERSE ? col - row : col + row;
  assign out_if.data   = out_valid ? bank_q[rd_bank_q][{src_col, row}] : '0;
  assign out_if.last   = out_valid && rd_cnt_q == 4'd15;
  always_comb begin
    bank_d = bank_q;
    if (wr_fire) bank_d[wr_bank_q][wr_cnt_q] = in_if.data;
    if (sync_clr) bank_d = '{default: '0};
    wr_cnt_d  = sync_clr ? '0 : wr_cnt_q + {3'd0, wr_fire};
    rd_cnt_d  = sync_clr ? '0 : rd_cnt_q + {3'd0, rd_fire};
    wr_bank_d = !sync_clr && (wr_bank_q ^ wr_done);
    rd_bank_d = !sync_clr && (rd_bank_q ^ rd_done);
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (sync_clr) full_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= '{default: '0};
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      bank_q    <= bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end
endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// tb_inv_shift_rows_stream: directed checks of the ping-pong (Inv)ShiftRows stream plus a forward/inverse chain round trip
module tb_inv_shift_rows_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clr = 1'b0;
  always #5 clk = ~clk;
  inv_shift_rows_stream_if #(.BYTE_W(8)) a_in(), a_out(), c_in(), c_mid(), c_out();
  inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_if(a_in.slave), .out_if(a_out.master));
  inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_if(c_in.slave), .out_if(c_mid.master));
  inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_if(c_mid.slave), .out_if(c_out.master));
  int chk = 0;
  int err = 0;
  int cyc = 0;
  int acc, stalls, hold_bad, first_out, last_out, acc16_cyc, cons16_cyc, rise_cyc;
  logic [7:0] out_q[$];
  int last_pos[$];
  logic [7:0] prev_data;
  logic prev_last, have_prev, prev_ready;
  int inv_perm[16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  int fwd_perm[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  task automatic clear_log();
    out_q.delete();
    last_pos.delete();
    acc = 0; stalls = 0; hold_bad = 0; first_out = -1; last_out = -1;
    acc16_cyc = -1; cons16_cyc = -1; rise_cyc = -1; have_prev = 0;
    prev_ready = a_in.ready;
  endtask
  task automatic step();
    @(negedge clk);
    if (!sync_clr) begin
      if (a_in.valid && a_in.ready) begin
        acc++;
        if (acc == 16) acc16_cyc = cyc;
      end
      if (a_in.valid && !a_in.ready) stalls++;
      if (a_in.ready && !prev_ready && rise_cyc < 0) rise_cyc = cyc;
      if (a_out.valid && a_out.ready) begin
        out_q.push_back(a_out.data);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (a_out.last) last_pos.push_back(out_q.size());
        if (out_q.size() == 16) cons16_cyc = cyc;
      end
      if (a_out.valid && !a_out.ready) begin
        if (have_prev && (a_out.data !== prev_data || a_out.last !== prev_last)) hold_bad++;
        have_prev = 1; prev_data = a_out.data; prev_last = a_out.last;
      end else have_prev = 0;
    end
    prev_ready = a_in.ready;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    a_in.valid = 0; a_out.ready = 0; sync_clr = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  task automatic test_reset();
    do_reset();
    chk++; if (a_in.ready !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %b want 1", a_in.ready); end
    chk++; if (a_out.valid !== 1'b0) begin err++; $display("FAIL reset_out_valid: got %b want 0", a_out.valid); end
    chk++; if (a_out.last !== 1'b0) begin err++; $display("FAIL reset_out_last: got %b want 0", a_out.last); end
    chk++; if (a_out.data !== 8'h00) begin err++; $display("FAIL reset_out_data: got %h want 00", a_out.data); end
    clear_log();
    a_in.valid = 1;
    for (int g = 0; g < 60 && acc < 21; g++) begin a_in.data = 8'(acc); step(); end
    a_in.valid = 0;
    chk++; if (a_out.valid !== 1'b1) begin err++; $display("FAIL pre_reset_out_valid: got %b want 1", a_out.valid); end
    #2 rst_n = 0;
    #1;
    chk++; if (a_in.ready !== 1'b1) begin err++; $display("FAIL async_reset_in_ready: got %b want 1", a_in.ready); end
    chk++; if (a_out.valid !== 1'b0) begin err++; $display("FAIL async_reset_out_valid: got %b want 0", a_out.valid); end
    chk++; if (a_out.last !== 1'b0) begin err++; $display("FAIL async_reset_out_last: got %b want 0", a_out.last); end
    chk++; if (a_out.data !== 8'h00) begin err++; $display("FAIL async_reset_out_data: got %h want 00", a_out.data); end
    @(posedge clk);
    #1 rst_n = 1;
    clear_log();
    a_out.ready = 1;
    repeat (20) step();
    chk++; if (out_q.size() != 0) begin err++; $display("FAIL reset_discard: got %0d bytes want 0", out_q.size()); end
  endtask
  task automatic test_inverse_block();
    do_reset();
    clear_log();
    a_out.ready = 1; a_in.valid = 1;
    for (int g = 0; g < 60 && acc < 16; g++) begin a_in.data = 8'(acc); step(); end
    a_in.valid = 0;
    for (int g = 0; g < 40 && out_q.size() < 16; g++) step();
    chk++; if (out_q.size() != 16) begin err++; $display("FAIL inv_count: got %0d want 16", out_q.size()); end
    while (out_q.size() < 16) out_q.push_back('x);
    for (int i = 0; i < 16; i++) begin
      chk++;
      if (out_q[i] !== 8'(inv_perm[i])) begin err++; $display("FAIL inv_byte%0d: got %h want %h", i, out_q[i], 8'(inv_perm[i])); end
    end
    chk++; if (!(last_pos.size() == 1 && last_pos[0] == 16)) begin err++; $display("FAIL inv_last: got %0d last beats want one at 16", last_pos.size()); end
    chk++; if (first_out != acc16_cyc + 1) begin err++; $display("FAIL inv_latency: got out at cycle %0d want %0d", first_out, acc16_cyc + 1); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    clear_log();
    a_out.ready = 1; a_in.valid = 1;
    for (int g = 0; g < 200 && acc < 48; g++) begin a_in.data = 8'(32 + acc); step(); end
    a_in.valid = 0;
    for (int g = 0; g < 60 && out_q.size() < 48; g++) step();
    chk++; if (stalls != 0) begin err++; $display("FAIL b2b_in_ready: got %0d stalls want 0", stalls); end
    chk++; if (out_q.size() != 48) begin err++; $display("FAIL b2b_count: got %0d want 48", out_q.size()); end
    chk++; if (last_out - first_out != 47) begin err++; $display("FAIL b2b_contiguous: got span %0d want 47", last_out - first_out); end
    chk++;
    if (!(last_pos.size() == 3 && last_pos[0] == 16 && last_pos[1] == 32 && last_pos[2] == 48)) begin
      err++; $display("FAIL b2b_last: got %0d last beats want 16/32/48", last_pos.size());
    end
    while (out_q.size() < 48) out_q.push_back('x);
    for (int i = 0; i < 48; i++) begin
      chk++;
      if (out_q[i] !== 8'(32 + 16 * (i / 16) + inv_perm[i % 16])) begin
        err++; $display("FAIL b2b_byte%0d: got %h want %h", i, out_q[i], 8'(32 + 16 * (i / 16) + inv_perm[i % 16]));
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    clear_log();
    a_out.ready = 0; a_in.valid = 1;
    for (int g = 0; g < 45; g++) begin a_in.data = 8'(acc); step(); end
    chk++; if (acc != 32) begin err++; $display("FAIL bp_accepted: got %0d want 32", acc); end
    chk++; if (a_in.ready !== 1'b0) begin err++; $display("FAIL bp_in_ready: got %b want 0", a_in.ready); end
    chk++; if (a_out.valid !== 1'b1) begin err++; $display("FAIL bp_out_valid: got %b want 1", a_out.valid); end
    chk++; if (a_out.data !== 8'h00) begin err++; $display("FAIL bp_out_data: got %h want 00", a_out.data); end
    chk++; if (hold_bad != 0) begin err++; $display("FAIL bp_hold: got %0d changes want 0", hold_bad); end
    a_out.ready = 1;
    for (int g = 0; g < 100 && acc < 40; g++) begin a_in.data = 8'(acc); step(); end
    a_in.valid = 0;
    for (int g = 0; g < 60 && out_q.size() < 32; g++) step();
    repeat (4) step();
    chk++; if (cons16_cyc < 0 || rise_cyc != cons16_cyc + 1) begin err++; $display("FAIL bp_ready_rise: got cycle %0d want %0d", rise_cyc, cons16_cyc + 1); end
    chk++; if (out_q.size() != 32) begin err++; $display("FAIL bp_count: got %0d want 32", out_q.size()); end
    chk++; if (!(last_pos.size() == 2 && last_pos[0] == 16 && last_pos[1] == 32)) begin err++; $display("FAIL bp_last: got %0d last beats want 16/32", last_pos.size()); end
    chk++; if (a_out.valid !== 1'b0) begin err++; $display("FAIL bp_partial_held: got out_valid %b want 0", a_out.valid); end
    while (out_q.size() < 32) out_q.push_back('x);
    for (int i = 0; i < 32; i++) begin
      chk++;
      if (out_q[i] !== 8'(16 * (i / 16) + inv_perm[i % 16])) begin
        err++; $display("FAIL bp_byte%0d: got %h want %h", i, out_q[i], 8'(16 * (i / 16) + inv_perm[i % 16]));
      end
    end
  endtask
  task automatic test_sync_clr();
    do_reset();
    clear_log();
    a_out.ready = 1; a_in.valid = 1;
    for (int g = 0; g < 20 && acc < 7; g++) begin a_in.data = 8'(8'hA0 + acc); step(); end
    sync_clr = 1; a_in.data = 8'hEE;
    step();
    sync_clr = 0;
    acc = 0;
    for (int g = 0; g < 40 && acc < 16; g++) begin a_in.data = 8'(16 + acc); step(); end
    a_in.valid = 0;
    repeat (40) step();
    chk++; if (out_q.size() != 16) begin err++; $display("FAIL clr_count: got %0d want 16", out_q.size()); end
    chk++; if (!(last_pos.size() == 1 && last_pos[0] == 16)) begin err++; $display("FAIL clr_last: got %0d last beats want one at 16", last_pos.size()); end
    chk++; if (a_out.valid !== 1'b0 || a_in.ready !== 1'b1) begin err++; $display("FAIL clr_idle: got valid %b ready %b want 0 1", a_out.valid, a_in.ready); end
    while (out_q.size() < 16) out_q.push_back('x);
    for (int i = 0; i < 16; i++) begin
      chk++;
      if (out_q[i] !== 8'(16 + inv_perm[i])) begin err++; $display("FAIL clr_byte%0d: got %h want %h", i, out_q[i], 8'(16 + inv_perm[i])); end
    end
  endtask
  task automatic test_chain();
    logic [7:0] src[1600];
    logic [7:0] mid_q[$];
    logic [7:0] dst_q[$];
    int sent, mid_bad, dst_bad;
    do_reset();
    for (int i = 0; i < 1600; i++) src[i] = 8'($urandom);
    sent = 0; mid_bad = 0; dst_bad = 0;
    for (int g = 0; g < 20000 && dst_q.size() < 1600; g++) begin
      c_in.valid = (sent < 1600) && ($urandom_range(0, 3) != 0);
      c_in.data = src[sent < 1600 ? sent : 0];
      c_out.ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (c_in.valid && c_in.ready) sent++;
      if (c_mid.valid && c_mid.ready) mid_q.push_back(c_mid.data);
      if (c_out.valid && c_out.ready) dst_q.push_back(c_out.data);
      @(posedge clk);
      #1;
    end
    c_in.valid = 0; c_out.ready = 0;
    chk++; if (mid_q.size() != 1600) begin err++; $display("FAIL chain_mid_count: got %0d want 1600", mid_q.size()); end
    chk++; if (dst_q.size() != 1600) begin err++; $display("FAIL chain_out_count: got %0d want 1600", dst_q.size()); end
    for (int i = 0; i < mid_q.size() && i < 1600; i++)
      if (mid_q[i] !== src[16 * (i / 16) + fwd_perm[i % 16]]) mid_bad++;
    for (int i = 0; i < dst_q.size() && i < 1600; i++)
      if (dst_q[i] !== src[i]) dst_bad++;
    chk++; if (mid_bad != 0) begin err++; $display("FAIL chain_forward_bytes: got %0d wrong want 0", mid_bad); end
    chk++; if (dst_bad != 0) begin err++; $display("FAIL chain_roundtrip_bytes: got %0d wrong want 0", dst_bad); end
  endtask
  initial begin
    a_in.valid = 0; a_in.data = '0; a_in.last = 0; a_out.ready = 0;
    c_in.valid = 0; c_in.data = '0; c_in.last = 0; c_out.ready = 0;
    test_reset();
    test_inverse_block();
    test_back_to_back();
    test_backpressure();
    test_sync_clr();
    test_chain();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
